alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 8, operand/result width (two's-complement signed).
- SETTLE_CYCLES, 1, cycles operands are held on the ALU before capture; legal range 1..15.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command offered.
- in_ready  out  1  command FIFO can accept.
- in_a  in  DATA_W  operand A (signed).
- in_b  in  DATA_W  operand B (signed).
- in_sel  in  2  ALU operation select.
- alu_a  out  DATA_W  operand A to the combinational ALU.
- alu_b  out  DATA_W  operand B to the combinational ALU.
- alu_sel  out  2  select to the combinational ALU.
- alu_s  in  DATA_W  ALU result (signed).
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  captured result (signed).
- out_sel  out  2  select that produced out_data.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.
- result_count  out  8  count of completed output handshakes.

Function
REQ-003 Input handshake SHALL occur on a rising edge where in_valid && in_ready; {in_a, in_b, in_sel} SHALL then be written to a 2-entry FIFO.
REQ-004 in_ready SHALL equal !full && !rst; there SHALL be no push when full and no bypass when empty.
REQ-005 When the FIFO holds one entry, simultaneous push and pop SHALL leave the occupancy at 1 with order preserved.
REQ-006 FSM states SHALL be IDLE, DRIVE and OUT.
REQ-007 IDLE with FIFO non-empty: pop the head into {alu_a, alu_b, alu_sel}, load settle counter with SETTLE_CYCLES-1, go to DRIVE.
REQ-008 DRIVE: if the counter is 0, capture alu_s into out_data and alu_sel into out_sel, set out_valid, go to OUT; otherwise decrement the counter.
REQ-009 alu_a, alu_b and alu_sel SHALL change only on a pop and SHALL otherwise hold their last values.
REQ-010 OUT: out_data, out_sel and out_valid SHALL hold while out_ready is low.
REQ-011 OUT with out_ready high:
- out_valid SHALL clear and result_count SHALL increment, wrapping 255 -> 0.
- If the FIFO is non-empty, pop in the same cycle and go to DRIVE (back-to-back).
- Otherwise go to IDLE.
REQ-012 Latency from input handshake edge N to out_valid rising SHALL be edge N+1+SETTLE_CYCLES.
REQ-013 Sustained throughput SHALL be one result per SETTLE_CYCLES+1 cycles.
REQ-014 Results SHALL emerge in command order; no result SHALL be dropped or duplicated.
REQ-015 The block SHALL perform no arithmetic on data; out_data SHALL be alu_s bit-exact.

Reset
REQ-016 While rst is high, all outputs SHALL be 0: in_ready, out_valid, out_data, out_sel, alu_a, alu_b, alu_sel, busy and result_count.
REQ-017 Reset SHALL also force the FSM to IDLE, empty the FIFO and zero the settle counter.
REQ-018 Reset asserted mid-operation (DRIVE or OUT) SHALL discard the in-flight command and all queued commands; no out_valid SHALL follow.
REQ-019 in_ready SHALL rise on the first clock edge after rst deasserts.

Verification
Bench stub for all scenarios: alu_s = alu_a + alu_b (sel ignored), SETTLE_CYCLES = 1 unless stated.
REQ-020 Single command: push a=0x01, b=0x80, sel=0 at edge N -> out_valid at N+2, out_data = 0x81 (-127), out_sel = 0, result_count = 1 after the handshake.
REQ-021 Back-pressure: push a=0x01, b=0xFF, sel=2; out_ready low 5 cycles -> out_data = 0x00 held stable throughout; push two more commands -> in_ready low after the second; out_ready high -> three results in order.
REQ-022 Back-to-back: three commands queued, out_ready held high -> out_valid pulses every 2 cycles; out_sel sequence matches input order.
REQ-023 SETTLE_CYCLES = 4: push a=0x08, b=0x01, sel=3 at edge N -> alu_a = 0x08 stable for 4 cycles; out_valid at N+5; out_data = 0x09.
REQ-024 Reset mid-DRIVE: assert rst asynchronously between edges -> all outputs 0 immediately; after release, no stale out_valid; a new command completes normally.
REQ-025 Wrap: complete 256 transactions -> result_count returns to 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage for an external combinational ALU: queues commands in a 2-deep FIFO,
// presents each to the ALU for SETTLE_CYCLES, then captures and holds the result.
module alu_issue_stage #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              busy,
    output logic [7:0]        result_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        OUT
    } state_t;

    localparam int ENTRY_W = 2 * DATA_W + 2;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               capture;
    logic               ready_en;
    logic [ENTRY_W-1:0] head;
    state_t             state;
    state_t             state_nxt;
    logic [3:0]         settle;
    logic [3:0]         settle_nxt;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    // ready_en keeps in_ready low until the first edge after reset release
    assign in_ready = ready_en && !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state != IDLE) || !empty;

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle;
        pop        = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    settle_nxt = SETTLE_LOAD;
                    state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end else begin
                    settle_nxt = settle - 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        settle_nxt = SETTLE_LOAD;
                        state_nxt  = DRIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            settle   <= 4'd0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            settle   <= settle_nxt;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_a, in_b, in_sel};
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= 2'd0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sel      <= 2'd0;
            result_count <= 8'd0;
        end else begin
            if (pop) begin
                {alu_a, alu_b, alu_sel} <= head;
            end
            if (capture) begin
                out_data  <= alu_s;
                out_sel   <= alu_sel;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) begin
                result_count <= result_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with an adder stub as the ALU;
// a second instance runs with SETTLE_CYCLES = 4.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic [1:0] in_sel = 2'd0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [7:0] alu_s;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic       busy;
    logic [7:0] result_count;

    logic       s4_in_valid = 1'b0;
    logic       s4_in_ready;
    logic [7:0] s4_in_a = 8'h00;
    logic [7:0] s4_in_b = 8'h00;
    logic [1:0] s4_in_sel = 2'd0;
    logic [7:0] s4_alu_a;
    logic [7:0] s4_alu_b;
    logic [1:0] s4_alu_sel;
    logic [7:0] s4_alu_s;
    logic       s4_out_valid;
    logic       s4_out_ready = 1'b0;
    logic [7:0] s4_out_data;
    logic [1:0] s4_out_sel;
    logic       s4_busy;
    logic [7:0] s4_result_count;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_cnt = 8'd0;

    assign alu_s    = alu_a + alu_b;
    assign s4_alu_s = s4_alu_a + s4_alu_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_stage #(.DATA_W(8), .SETTLE_CYCLES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sel       (in_sel),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_s        (alu_s),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .busy         (busy),
        .result_count (result_count)
    );

    alu_issue_stage #(.DATA_W(8), .SETTLE_CYCLES(4)) dut_s4 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (s4_in_valid),
        .in_ready     (s4_in_ready),
        .in_a         (s4_in_a),
        .in_b         (s4_in_b),
        .in_sel       (s4_in_sel),
        .alu_a        (s4_alu_a),
        .alu_b        (s4_alu_b),
        .alu_sel      (s4_alu_sel),
        .alu_s        (s4_alu_s),
        .out_valid    (s4_out_valid),
        .out_ready    (s4_out_ready),
        .out_data     (s4_out_data),
        .out_sel      (s4_out_sel),
        .busy         (s4_busy),
        .result_count (s4_result_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] sel, output int lat,
                          output logic [7:0] d, output logic [1:0] s);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
        step();
        in_valid = 1'b0;
        lat      = 0;
        d        = 8'hxx;
        s        = 2'bxx;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        if (out_valid) begin
            d         = out_data;
            s         = out_sel;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [38:0] z;
        #1 rst = 1'b1;
        step();
        step();
        z = {in_ready, out_valid, out_data, out_sel, alu_a, alu_b,
             alu_sel, busy, result_count};
        n_checks++;
        if (z !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", z);
        end
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_edge: got %b expected 0", in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_edge: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_a     = 8'h01;
        in_b     = 8'h80;
        in_sel   = 2'd0;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_n0: got valid=%b busy=%b expected 0 1", out_valid, busy);
        end
        step();
        n_checks++;
        if (alu_a !== 8'h01 || alu_b !== 8'h80 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n1: got a=%h b=%h v=%b expected 01 80 0",
                     alu_a, alu_b, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h81 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL single_n2: got v=%b d=%h s=%0d expected 1 81 0",
                     out_valid, out_data, out_sel);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (out_valid !== 1'b0 || result_count !== exp_cnt || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got v=%b cnt=%0d busy=%b expected 0 %0d 0",
                     out_valid, result_count, busy, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ed [3];
        logic [1:0] es [3];
        int got;
        ed[0] = 8'h00; es[0] = 2'd2;
        ed[1] = 8'h30; es[1] = 2'd1;
        ed[2] = 8'h70; es[2] = 2'd3;
        in_valid = 1'b1;
        in_a     = 8'h01;
        in_b     = 8'hFF;
        in_sel   = 2'd2;
        step();
        in_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_first: got v=%b d=%h expected 1 00", out_valid, out_data);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_sel = 2'd1;
            end else if (i == 1) begin
                in_valid = 1'b1; in_a = 8'h30; in_b = 8'h40; in_sel = 2'd3;
            end else begin
                in_valid = 1'b0;
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h00 || out_sel !== 2'd2) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d expected 1 00 2",
                         i, out_valid, out_data, out_sel);
            end
            if (i == 1) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_full: got in_ready=%b expected 0", in_ready);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && got < 3; t++) begin
            if (out_valid) begin
                n_checks++;
                if (out_data !== ed[got] || out_sel !== es[got]) begin
                    n_fail++;
                    $display("FAIL bp_result[%0d]: got d=%h s=%0d expected %h %0d",
                             got, out_data, out_sel, ed[got], es[got]);
                end
                got++;
            end
            step();
        end
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'(got);
        n_checks++;
        if (got != 3 || result_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results cnt=%0d expected 3 cnt=%0d",
                     got, result_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int hs [3];
        logic [1:0] es [3];
        logic [7:0] ed [3];
        int got;
        es[0] = 2'd1; ed[0] = 8'h03;
        es[1] = 2'd2; ed[1] = 8'h07;
        es[2] = 2'd3; ed[2] = 8'h0B;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(2 * i + 1);
            in_b     = 8'(2 * i + 2);
            in_sel   = es[i];
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && got < 3; t++) begin
            if (out_valid) begin
                hs[got] = cyc;
                n_checks++;
                if (out_sel !== es[got] || out_data !== ed[got]) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got s=%0d d=%h expected %0d %h",
                             got, out_sel, out_data, es[got], ed[got]);
                end
                got++;
            end
            step();
        end
        out_ready = 1'b0;
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 3", got);
        end else begin
            n_checks++;
            if (hs[1] - hs[0] != 2 || hs[2] - hs[1] != 2) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d %0d expected 2 2",
                         hs[1] - hs[0], hs[2] - hs[1]);
            end
        end
        exp_cnt = exp_cnt + 8'(got);
        n_checks++;
        if (result_count !== exp_cnt || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got cnt=%0d busy=%b expected %0d 0",
                     result_count, busy, exp_cnt);
        end
    endtask

    task automatic test_settle4();
        s4_in_valid = 1'b1;
        s4_in_a     = 8'h08;
        s4_in_b     = 8'h01;
        s4_in_sel   = 2'd3;
        step();
        s4_in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (s4_alu_a !== 8'h08 || s4_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL s4_drive[%0d]: got a=%h v=%b expected 08 0",
                         k, s4_alu_a, s4_out_valid);
            end
        end
        step();
        n_checks++;
        if (s4_out_valid !== 1'b1 || s4_out_data !== 8'h09 || s4_out_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL s4_out: got v=%b d=%h s=%0d expected 1 09 3",
                     s4_out_valid, s4_out_data, s4_out_sel);
        end
        s4_out_ready = 1'b1;
        step();
        s4_out_ready = 1'b0;
        n_checks++;
        if (s4_out_valid !== 1'b0 || s4_result_count !== 8'd1) begin
            n_fail++;
            $display("FAIL s4_done: got v=%b cnt=%0d expected 0 1",
                     s4_out_valid, s4_result_count);
        end
    endtask

    task automatic test_reset_mid_drive();
        logic [38:0] z;
        int lat;
        logic [7:0] d;
        logic [1:0] s;
        int seen;
        in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_sel = 2'd1;
        step();
        in_valid = 1'b1; in_a = 8'h05; in_b = 8'h05; in_sel = 2'd2;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        z = {in_ready, out_valid, out_data, out_sel, alu_a, alu_b,
             alu_sel, busy, result_count};
        n_checks++;
        if (z !== 39'd0) begin
            n_fail++;
            $display("FAIL rst_mid_zero: got %h expected 0", z);
        end
        exp_cnt = 8'd0;
        step();
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid || busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_stale: got %0d active cycles expected 0", seen);
        end
        do_txn(8'h22, 8'h11, 2'd1, lat, d, s);
        exp_cnt++;
        n_checks++;
        if (lat != 2 || d !== 8'h33 || s !== 2'd1 || result_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL rst_mid_new: got lat=%0d d=%h s=%0d cnt=%0d expected 2 33 1 %0d",
                     lat, d, s, result_count, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [7:0] d;
        logic [1:0] s;
        logic [7:0] start;
        logic [7:0] a;
        start = exp_cnt;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            do_txn(a, 8'h01, a[1:0], lat, d, s);
            exp_cnt++;
            n_checks++;
            if (lat != 2 || d !== a + 8'h01 || s !== a[1:0]) begin
                n_fail++;
                $display("FAIL wrap_txn[%0d]: got lat=%0d d=%h s=%0d expected 2 %h %0d",
                         i, lat, d, s, a + 8'h01, a[1:0]);
            end
            if (exp_cnt == 8'd0) begin
                n_checks++;
                if (result_count !== 8'd0) begin
                    n_fail++;
                    $display("FAIL wrap_zero: got %0d expected 0", result_count);
                end
            end
        end
        n_checks++;
        if (result_count !== start) begin
            n_fail++;
            $display("FAIL wrap_end: got %0d expected %0d", result_count, start);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_settle4();
        test_reset_mid_drive();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
